// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and single-outstanding instruction fetcher feeding decode,
// with a one-entry skid buffer and redirect handling that kills stale responses.
`default_nettype none

`ifndef BUBBLE
`define BUBBLE 32'h0000_0013
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_insn_q, buf_insn_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_insn_q, out_insn_d;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    kill_d         = kill_q;
    buf_pc_d       = buf_pc_q;
    buf_insn_d     = buf_insn_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_insn_d     = out_insn_q;
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;

    // Decode consumes the current slot; a load below may refill it.
    if (!stall) begin
      out_valid_d = 1'b0;
      out_insn_d  = `BUBBLE;
    end

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!out_valid_q || !stall) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_insn_d  = imem_resp_data;
            pc_d        = req_pc_q + 32'd4;
            state_d     = S_REQ;
          end else begin
            buf_pc_d   = req_pc_q;
            buf_insn_d = imem_resp_data;
            pc_d       = req_pc_q + 32'd4;
            state_d    = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!stall) begin
          out_valid_d = 1'b1;
          out_pc_d    = buf_pc_q;
          out_insn_d  = buf_insn_q;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything; an in-flight request must be killed.
    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      out_insn_d  = `BUBBLE;
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      kill_q      <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_insn_q  <= `BUBBLE;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_insn_q  <= `BUBBLE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      buf_pc_q    <= buf_pc_d;
      buf_insn_q  <= buf_insn_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_insn_q  <= out_insn_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_instruction = out_insn_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, hand-computed sequence for fetch_unit with immediate assertions.
`default_nettype none

`ifndef BUBBLE
`define BUBBLE 32'h0000_0013
`endif

module tb_fetch_unit;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] insn);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, v});
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".insn"}, out_instruction, insn);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
    chk({tag, ".req_valid"}, {31'h0, imem_req_valid}, {31'h0, v});
    if (v) chk({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    step(); step(); step();

    // Reset released: first request to RESET_PC, bubble on output
    reset = 1'b0;
    chk_req("reset_req", 1'b1, 32'h100);
    chk_out("reset_out", 1'b0, 32'h0, BUB);

    // Straight-line fetch
    imem_req_ready = 1'b1;
    step();
    chk_req("wait0", 1'b0, 32'h0);
    chk_out("wait0_out", 1'b0, 32'h0, BUB);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    step();
    imem_resp_valid = 1'b0;
    chk_out("insn0", 1'b1, 32'h100, 32'h0050_0093);
    chk_req("req1", 1'b1, 32'h104);
    step();
    chk_out("consumed0", 1'b0, 32'h100, BUB);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0113;
    step();
    imem_resp_valid = 1'b0;
    chk_out("insn1", 1'b1, 32'h104, 32'h00A0_0113);
    chk_req("req2", 1'b1, 32'h108);

    // Stall with skid buffer
    stall = 1'b1;
    step();
    chk_out("stall_hold0", 1'b1, 32'h104, 32'h00A0_0113);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_8193;
    step();
    imem_resp_valid = 1'b0;
    chk_req("full_noreq", 1'b0, 32'h0);
    chk_out("full_hold", 1'b1, 32'h104, 32'h00A0_0113);
    step();
    chk_req("full_noreq2", 1'b0, 32'h0);
    chk_out("full_hold2", 1'b1, 32'h104, 32'h00A0_0113);
    stall = 1'b0;
    step();
    chk_out("skid_drain", 1'b1, 32'h108, 32'h0030_8193);
    chk_req("after_skid", 1'b1, 32'h10C);

    // Redirect while waiting: the pending response must be dropped
    step();
    chk_req("wait_r", 1'b0, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    chk_req("killed_wait", 1'b0, 32'h0);
    chk_out("redir_out", 1'b0, 32'h108, BUB);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk_out("stale_dropped", 1'b0, 32'h108, BUB);
    chk_req("req_target", 1'b1, 32'h200);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0073;
    step();
    imem_resp_valid = 1'b0;
    chk_out("target_insn", 1'b1, 32'h200, 32'h0010_0073);
    chk_req("req_204", 1'b1, 32'h204);

    // Redirect with stall while the buffer is full
    stall = 1'b1;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    step();
    imem_resp_valid = 1'b0;
    chk_req("full2_noreq", 1'b0, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b0;
    chk_out("redir_full_out", 1'b0, 32'h200, BUB);
    chk_req("redir_full_req", 1'b1, 32'h300);
    step();
    chk_out("buf_discarded", 1'b0, 32'h200, BUB);
    chk_req("req_hold_noready", 1'b1, 32'h300);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk_req("req_fffc", 1'b1, 32'hFFFF_FFFC);
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
    step();
    imem_resp_valid = 1'b0;
    chk_out("wrap_insn", 1'b1, 32'hFFFF_FFFC, 32'h2222_2222);
    chk_req("wrap_addr", 1'b1, 32'h0);

    // Reset asserted mid-transaction, late response ignored
    imem_req_ready = 1'b1;
    step();
    chk_req("wait_before_rst", 1'b0, 32'h0);
    reset = 1'b1;
    step();
    chk_req("rst_req", 1'b1, 32'h100);
    chk_out("rst_out", 1'b0, 32'h0, BUB);
    reset = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333;
    step();
    imem_resp_valid = 1'b0;
    chk_out("late_resp_ignored", 1'b0, 32'h0, BUB);
    chk_req("post_rst_req", 1'b1, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
